// File: rtl/dbus_link_scheduler_pkg.sv
// Shared definitions for the UART <-> DBUS transfer scheduler: state
// encodings, transfer directions and the timeout counter sizing helper.
package dbus_link_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DRAIN     = 3'd4
    } sched_state_t;

    localparam logic DIR_OUT = 1'b0;  // UART RX FIFO -> DBUS
    localparam logic DIR_IN  = 1'b1;  // DBUS -> UART TX FIFO

    // Bits needed to hold 0..limit inclusive.
    function automatic int timeout_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dbus_link_scheduler_if.sv
// Handshake/data bundle between the scheduler, the UART FIFOs and the DBUS
// link engine. The scheduler takes the master side; the FIFOs and the link
// engine together form the slave side.
interface dbus_link_scheduler_if;

    logic       i_rx_avail;
    logic [7:0] i_rx_data;
    logic       o_rx_read;

    logic [7:0] o_dbus_data;
    logic       o_dbus_enable;
    logic       i_dbus_busy;
    logic       i_dbus_avail;
    logic [7:0] i_dbus_data;
    logic       o_dbus_read;

    logic [7:0] o_tx_data;
    logic       o_tx_enable;
    logic       i_tx_busy;
    logic       i_tx_full;

    modport master (
        input  i_rx_avail, i_rx_data, i_dbus_busy, i_dbus_avail, i_dbus_data,
               i_tx_busy, i_tx_full,
        output o_rx_read, o_dbus_data, o_dbus_enable, o_dbus_read,
               o_tx_data, o_tx_enable
    );

    modport slave (
        output i_rx_avail, i_rx_data, i_dbus_busy, i_dbus_avail, i_dbus_data,
               i_tx_busy, i_tx_full,
        input  o_rx_read, o_dbus_data, o_dbus_enable, o_dbus_read,
               o_tx_data, o_tx_enable
    );

endinterface

// File: rtl/dbus_link_scheduler_timeout.sv
// Stall watchdog for the scheduler: clearable up-counter whose terminal
// flag fires in the c_LIMIT-th cycle of a run, so the abort edge ends the
// state after exactly c_LIMIT cycles.
module sched_timeout
    import dbus_link_scheduler_pkg::*;
#(
    parameter int c_LIMIT = 65535
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int c_WIDTH = timeout_width(c_LIMIT);

    logic [c_WIDTH-1:0] count;

    // Count cycles spent in the current state; restart on every state entry.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_run && !o_expired) begin
            count <= count + 1'b1;
        end
    end

    assign o_expired = i_run && (count == c_WIDTH'(c_LIMIT - 1));

endmodule

// File: rtl/dbus_link_scheduler.sv
// Half-duplex byte scheduler between the UART FIFOs and the DBUS link
// engine. Inbound DBUS bytes take priority; stalled handshakes are aborted
// by a watchdog and reported through a sticky error flag.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | no transfer; waits for an inbound or outbound byte
//   FETCH      | RX byte latched, o_rx_read held until RX FIFO drops avail
//   SEND       | o_dbus_enable held until the link engine reports busy
//   WAIT_DONE  | waits for the link engine to finish sending
//   DRAIN      | DBUS byte written to TX FIFO, o_dbus_read held until avail drops
module dbus_link_scheduler
    import dbus_link_scheduler_pkg::*;
#(
    parameter int c_TIMEOUT    = 65535,
    parameter int c_COUNTWIDTH = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    dbus_link_scheduler_if.master   bus,
    input  logic                    i_clear_error,
    output logic                    o_error,
    output logic                    o_error_dir,
    output logic [c_COUNTWIDTH-1:0] o_sent_count,
    output logic [c_COUNTWIDTH-1:0] o_recv_count,
    output logic                    o_idle
);

    sched_state_t state, state_next;

    logic rx_avail_q, dbus_busy_q, dbus_avail_q, tx_busy_q, tx_full_q;
    logic timed_out;
    logic latch_out, latch_in, done_out, done_in, abort;
    logic tx_enable_q;

    // Status inputs come from other blocks; every decision uses these copies.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_avail_q   <= 1'b0;
            dbus_busy_q  <= 1'b0;
            dbus_avail_q <= 1'b0;
            tx_busy_q    <= 1'b0;
            tx_full_q    <= 1'b0;
        end else begin
            rx_avail_q   <= bus.i_rx_avail;
            dbus_busy_q  <= bus.i_dbus_busy;
            dbus_avail_q <= bus.i_dbus_avail;
            tx_busy_q    <= bus.i_tx_busy;
            tx_full_q    <= bus.i_tx_full;
        end
    end

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and transfer events; a handshake completing in the final
    // allowed cycle counts as done rather than aborted.
    always_comb begin
        state_next = state;
        latch_out  = 1'b0;
        latch_in   = 1'b0;
        done_out   = 1'b0;
        done_in    = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dbus_avail_q && !tx_busy_q && !tx_full_q) begin
                    state_next = ST_DRAIN;
                    latch_in   = 1'b1;
                end else if (rx_avail_q && !dbus_busy_q && !dbus_avail_q) begin
                    state_next = ST_FETCH;
                    latch_out  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (!rx_avail_q) begin
                    state_next = ST_SEND;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            ST_SEND: begin
                if (dbus_busy_q) begin
                    state_next = ST_WAIT_DONE;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!dbus_busy_q) begin
                    state_next = ST_IDLE;
                    done_out   = 1'b1;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!dbus_avail_q) begin
                    state_next = ST_IDLE;
                    done_in    = 1'b1;
                end else if (timed_out) begin
                    abort = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    sched_timeout #(
        .c_LIMIT (c_TIMEOUT)
    ) u_timeout (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (state_next != state),
        .i_run     (state != ST_IDLE),
        .o_expired (timed_out)
    );

    // Data latches, TX write strobe, byte counters and the sticky error.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus.o_dbus_data <= '0;
            bus.o_tx_data   <= '0;
            tx_enable_q     <= 1'b0;
            o_sent_count    <= '0;
            o_recv_count    <= '0;
            o_error         <= 1'b0;
            o_error_dir     <= DIR_OUT;
        end else begin
            tx_enable_q <= latch_in;
            if (latch_out) begin
                bus.o_dbus_data <= bus.i_rx_data;
            end
            if (latch_in) begin
                bus.o_tx_data <= bus.i_dbus_data;
            end
            if (done_out) begin
                o_sent_count <= o_sent_count + 1'b1;
            end
            if (done_in) begin
                o_recv_count <= o_recv_count + 1'b1;
            end
            if (abort) begin
                o_error     <= 1'b1;
                o_error_dir <= (state == ST_DRAIN) ? DIR_IN : DIR_OUT;
            end else if (i_clear_error) begin
                o_error <= 1'b0;
            end
        end
    end

    assign bus.o_rx_read     = (state == ST_FETCH);
    assign bus.o_dbus_enable = (state == ST_SEND);
    assign bus.o_dbus_read   = (state == ST_DRAIN);
    assign bus.o_tx_enable   = tx_enable_q;
    assign o_idle            = (state == ST_IDLE);

endmodule

// File: tb/tb_dbus_link_scheduler.sv
// Directed bench for dbus_link_scheduler with a short timeout and narrow
// counters so the abort and wrap cases stay quick.
module tb_dbus_link_scheduler;

    localparam int c_TIMEOUT    = 16;
    localparam int c_COUNTWIDTH = 4;

    logic                    clock = 1'b0;
    logic                    reset_n;
    logic                    clear_error;
    logic                    error;
    logic                    error_dir;
    logic [c_COUNTWIDTH-1:0] sent_count;
    logic [c_COUNTWIDTH-1:0] recv_count;
    logic                    idle;

    int checks   = 0;
    int failures = 0;

    dbus_link_scheduler_if bus ();

    dbus_link_scheduler #(
        .c_TIMEOUT    (c_TIMEOUT),
        .c_COUNTWIDTH (c_COUNTWIDTH)
    ) dut (
        .i_clock       (clock),
        .i_reset_n     (reset_n),
        .bus           (bus),
        .i_clear_error (clear_error),
        .o_error       (error),
        .o_error_dir   (error_dir),
        .o_sent_count  (sent_count),
        .o_recv_count  (recv_count),
        .o_idle        (idle)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic drive_quiet();
        bus.i_rx_avail   = 1'b0;
        bus.i_rx_data    = 8'h00;
        bus.i_dbus_busy  = 1'b0;
        bus.i_dbus_avail = 1'b0;
        bus.i_dbus_data  = 8'h00;
        bus.i_tx_busy    = 1'b0;
        bus.i_tx_full    = 1'b0;
        clear_error      = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drive_quiet();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_rx_read"},   bus.o_rx_read,     0);
        check_value({tag, "_dbus_en"},   bus.o_dbus_enable, 0);
        check_value({tag, "_dbus_read"}, bus.o_dbus_read,   0);
        check_value({tag, "_tx_en"},     bus.o_tx_enable,   0);
        check_value({tag, "_dbus_data"}, bus.o_dbus_data,   0);
        check_value({tag, "_tx_data"},   bus.o_tx_data,     0);
        check_value({tag, "_error"},     error,             0);
        check_value({tag, "_error_dir"}, error_dir,         0);
        check_value({tag, "_sent"},      sent_count,        0);
        check_value({tag, "_recv"},      recv_count,        0);
        check_value({tag, "_idle"},      idle,              1);
    endtask

    // Completes an outbound byte once o_rx_read is up: the FIFO drops avail,
    // the link engine acks after 3 cycles and stays busy for 3 more.
    task automatic finish_outbound();
        bus.i_rx_avail = 1'b0;
        for (int n = 0; n < 10 && bus.o_dbus_enable !== 1'b1; n++) tick();
        check_value("send_req", bus.o_dbus_enable, 1);
        repeat (3) tick();
        bus.i_dbus_busy = 1'b1;
        for (int n = 0; n < 10 && bus.o_dbus_enable !== 1'b0; n++) tick();
        check_value("send_release", bus.o_dbus_enable, 0);
        repeat (2) tick();
        bus.i_dbus_busy = 1'b0;
        for (int n = 0; n < 10 && idle !== 1'b1; n++) tick();
        check_value("out_done_idle", idle, 1);
        tick();
    endtask

    task automatic outbound_byte(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_avail = 1'b1;
        for (int n = 0; n < 10 && bus.o_rx_read !== 1'b1; n++) tick();
        check_value("rx_read", bus.o_rx_read, 1);
        check_value("dbus_data", bus.o_dbus_data, b);
        finish_outbound();
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        drive_quiet();
        apply_reset();
        check_reset_outputs("reset");

        // Single outbound byte with exact handshake latencies.
        bus.i_rx_data  = 8'hA5;
        bus.i_rx_avail = 1'b1;
        tick();
        check_value("rx_read_early", bus.o_rx_read, 0);
        tick();
        check_value("rx_read_lat2", bus.o_rx_read, 1);
        check_value("out_dbus_data", bus.o_dbus_data, 8'hA5);
        bus.i_rx_avail = 1'b0;
        tick();
        check_value("rx_read_hold", bus.o_rx_read, 1);
        tick();
        check_value("rx_read_drop", bus.o_rx_read, 0);
        check_value("dbus_en_lat2", bus.o_dbus_enable, 1);
        repeat (3) tick();
        bus.i_dbus_busy = 1'b1;
        tick();
        check_value("dbus_en_hold", bus.o_dbus_enable, 1);
        tick();
        check_value("dbus_en_drop", bus.o_dbus_enable, 0);
        tick();
        bus.i_dbus_busy = 1'b0;
        tick();
        check_value("wait_done_busy", idle, 0);
        tick();
        check_value("out_back_idle", idle, 1);
        check_value("out_sent1", sent_count, 1);
        check_value("out_no_error", error, 0);

        // Both directions ready together: inbound first, then outbound.
        apply_reset();
        bus.i_rx_data    = 8'h77;
        bus.i_rx_avail   = 1'b1;
        bus.i_dbus_data  = 8'h3C;
        bus.i_dbus_avail = 1'b1;
        tick();
        check_value("sim_tx_en_early", bus.o_tx_enable, 0);
        tick();
        check_value("sim_dbus_read", bus.o_dbus_read, 1);
        check_value("sim_tx_en", bus.o_tx_enable, 1);
        check_value("sim_tx_data", bus.o_tx_data, 8'h3C);
        check_value("sim_rx_waits", bus.o_rx_read, 0);
        bus.i_dbus_avail = 1'b0;
        tick();
        check_value("sim_tx_en_pulse", bus.o_tx_enable, 0);
        for (n = 0; n < 10 && idle !== 1'b1; n++) tick();
        check_value("sim_recv1", recv_count, 1);
        for (n = 0; n < 10 && bus.o_rx_read !== 1'b1; n++) tick();
        check_value("sim_rx_read", bus.o_rx_read, 1);
        check_value("sim_dbus_data", bus.o_dbus_data, 8'h77);
        finish_outbound();
        check_value("sim_sent_final", sent_count, 1);
        check_value("sim_recv_final", recv_count, 1);

        // TX FIFO full blocks inbound; release starts it 2 cycles later.
        apply_reset();
        bus.i_tx_full    = 1'b1;
        bus.i_dbus_data  = 8'h5A;
        bus.i_dbus_avail = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check_value("full_no_read", bus.o_dbus_read, 0);
            check_value("full_idle", idle, 1);
            tick();
        end
        bus.i_tx_full = 1'b0;
        tick();
        tick();
        check_value("full_rel_read", bus.o_dbus_read, 1);
        check_value("full_rel_tx_en", bus.o_tx_enable, 1);
        check_value("full_rel_tx_data", bus.o_tx_data, 8'h5A);
        bus.i_dbus_avail = 1'b0;
        for (n = 0; n < 10 && idle !== 1'b1; n++) tick();
        check_value("full_recv1", recv_count, 1);

        // Outbound timeout: link engine never raises busy.
        apply_reset();
        bus.i_rx_data  = 8'hC3;
        bus.i_rx_avail = 1'b1;
        for (n = 0; n < 10 && bus.o_rx_read !== 1'b1; n++) tick();
        bus.i_rx_avail = 1'b0;
        for (n = 0; n < 10 && bus.o_dbus_enable !== 1'b1; n++) tick();
        check_value("to_send_entry", bus.o_dbus_enable, 1);
        n = 0;
        while (bus.o_dbus_enable === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_value("to_send_len", n, 16);
        check_value("to_error", error, 1);
        check_value("to_error_dir", error_dir, 0);
        check_value("to_sent_kept", sent_count, 0);
        check_value("to_idle", idle, 1);

        // Inbound timeout with clear_error on the abort edge: set wins.
        repeat (2) tick();
        bus.i_dbus_data  = 8'h11;
        bus.i_dbus_avail = 1'b1;
        for (n = 0; n < 10 && bus.o_dbus_read !== 1'b1; n++) tick();
        repeat (15) tick();
        check_value("to2_drain_hold", bus.o_dbus_read, 1);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check_value("to2_read_drop", bus.o_dbus_read, 0);
        check_value("to2_error_kept", error, 1);
        check_value("to2_error_dir", error_dir, 1);
        check_value("to2_recv_kept", recv_count, 0);
        bus.i_dbus_avail = 1'b0;
        repeat (6) tick();
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check_value("clear_error", error, 0);

        // 4-bit sent counter wraps after 16 bytes.
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            outbound_byte(8'(8'h10 + i));
            check_value("wrap_sent", sent_count, (i + 1) % 16);
        end
        check_value("wrap_final", sent_count, 1);
        check_value("wrap_recv", recv_count, 0);

        // Reset asserted while waiting for the link engine to finish.
        apply_reset();
        outbound_byte(8'h42);
        bus.i_rx_data  = 8'h99;
        bus.i_rx_avail = 1'b1;
        for (n = 0; n < 10 && bus.o_rx_read !== 1'b1; n++) tick();
        bus.i_rx_avail = 1'b0;
        for (n = 0; n < 10 && bus.o_dbus_enable !== 1'b1; n++) tick();
        bus.i_dbus_busy = 1'b1;
        for (n = 0; n < 10 && bus.o_dbus_enable !== 1'b0; n++) tick();
        check_value("mid_in_wait_done", idle, 0);
        check_value("mid_sent_before", sent_count, 1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        tick();
        bus.i_dbus_busy = 1'b0;
        reset_n = 1'b1;
        repeat (3) tick();
        check_value("post_rst_sent", sent_count, 0);
        check_value("post_rst_recv", recv_count, 0);
        check_value("post_rst_idle", idle, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
